// File: rtl/tlp_cpl_tx.sv
// Completion transmitter: answers one decoded memory-read request at a time with a
// 3DW CplD (data fetched from the 16-bit BAR memory) or a UR Cpl, on a 16-bit TX stream.
module tlp_cpl_tx #(
    parameter int ADDR_W     = 13,
    parameter int MAX_LEN_DW = 32
) (
    input  logic              clk_125,
    input  logic              sys_rst,
    input  logic [7:0]        bus_num,
    input  logic [4:0]        dev_num,
    input  logic [2:0]        func_num,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [15:0]       req_id,
    input  logic [7:0]        req_tag,
    input  logic [2:0]        req_tc,
    input  logic [1:0]        req_attr,
    input  logic [9:0]        req_len,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-2:0] mem_addr,
    input  logic [15:0]       mem_rd_data,
    output logic              tx_req,
    input  logic              tx_rdy,
    output logic              tx_st,
    output logic              tx_end,
    output logic [15:0]       tx_data
);
    localparam int CNT_W = $clog2(2 * MAX_LEN_DW + 1);

    typedef enum logic [1:0] {IDLE, ARB, HDR, DATA} state_t;
    state_t state;

    logic [15:0]      r_id;
    logic [7:0]       r_tag;
    logic [2:0]       r_tc;
    logic [1:0]       r_attr;
    logic [9:0]       r_len;
    logic [4:0]       r_alo;
    logic             r_ur;
    logic [2:0]       hcnt;
    logic [CNT_W-1:0] dcnt;
    logic [5:0][15:0] hdr;

    logic             ur_in, accept, pop;
    logic [CNT_W-1:0] rd_left;
    logic [ADDR_W-2:0] rd_addr;
    logic             rd_vld;
    logic [15:0]      fifo [4];
    logic [1:0]       wp, rp;
    logic [2:0]       cnt;
    logic [3:0]       credit;
    logic             unused;

    assign unused = ^req_addr[1:0];
    assign ur_in  = (req_len == 10'd0) || (req_len > 10'(MAX_LEN_DW));
    assign accept = (state == IDLE) && req_ready && req_valid;
    // Data words leave the prefetch buffer when the last header word or a non-final data word is consumed
    assign pop    = tx_rdy && (((state == HDR) && (hcnt == 3'd5) && !r_ur) ||
                               ((state == DATA) && !tx_end));

    always_comb begin
        hdr[0] = {1'b0, (r_ur ? 2'b00 : 2'b10), 5'b01010, 1'b0, r_tc, 4'b0000};
        hdr[1] = {2'b00, r_attr, 2'b00, (r_ur ? 10'd0 : r_len)};
        hdr[2] = {bus_num, dev_num, func_num};
        hdr[3] = r_ur ? 16'h2004 : {4'b0000, r_len, 2'b00};
        hdr[4] = r_id;
        hdr[5] = {r_tag, 1'b0, r_alo, 2'b00};
    end

    always_ff @(posedge clk_125) begin
        if (sys_rst) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            tx_req    <= 1'b0;
            tx_st     <= 1'b0;
            tx_end    <= 1'b0;
            tx_data   <= '0;
            hcnt      <= '0;
            dcnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        tx_req    <= 1'b1;
                        r_id      <= req_id;
                        r_tag     <= req_tag;
                        r_tc      <= req_tc;
                        r_attr    <= req_attr;
                        r_len     <= req_len;
                        r_alo     <= req_addr[6:2];
                        r_ur      <= ur_in;
                        state     <= ARB;
                    end
                end
                ARB: if (tx_rdy) begin
                    tx_req  <= 1'b0;
                    tx_st   <= 1'b1;
                    tx_end  <= 1'b0;
                    tx_data <= hdr[0];
                    hcnt    <= '0;
                    state   <= HDR;
                end
                HDR: if (tx_rdy) begin
                    tx_st <= 1'b0;
                    if (hcnt == 3'd5) begin
                        if (r_ur) begin
                            tx_end    <= 1'b0;
                            tx_data   <= '0;
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            tx_data <= fifo[rp];
                            tx_end  <= 1'b0;
                            dcnt    <= CNT_W'({r_len, 1'b0}) - 1'b1;
                            state   <= DATA;
                        end
                    end else begin
                        hcnt    <= hcnt + 3'd1;
                        tx_data <= hdr[hcnt + 3'd1];
                        tx_end  <= r_ur && (hcnt == 3'd4);
                    end
                end
                DATA: if (tx_rdy) begin
                    if (tx_end) begin
                        tx_end    <= 1'b0;
                        tx_data   <= '0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tx_data <= fifo[rp];
                        dcnt    <= dcnt - 1'b1;
                        tx_end  <= (dcnt == CNT_W'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Prefetch keeps buffered + in-flight words at most 4, enough to hide the
    // two-edge read-to-buffer latency while streaming one word per cycle.
    assign credit = 4'(cnt) + 4'(rd_vld) + 4'(mem_rd_en) - 4'(pop);

    always_ff @(posedge clk_125) begin
        if (sys_rst) begin
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            rd_vld    <= 1'b0;
            rd_left   <= '0;
            rd_addr   <= '0;
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
        end else begin
            rd_vld <= mem_rd_en;
            if (rd_vld) wp <= wp + 2'd1;
            if (pop) rp <= rp + 2'd1;
            cnt <= cnt + 3'(rd_vld) - 3'(pop);
            if (accept) begin
                rd_left   <= ur_in ? '0 : CNT_W'({req_len, 1'b0});
                rd_addr   <= {req_addr[ADDR_W-1:2], 1'b0};
                mem_rd_en <= 1'b0;
            end else if ((rd_left != '0) && (credit < 4'd4)) begin
                mem_rd_en <= 1'b1;
                mem_addr  <= rd_addr;
                rd_addr   <= rd_addr + 1'b1;
                rd_left   <= rd_left - 1'b1;
            end else begin
                mem_rd_en <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_125) begin
        if (rd_vld) fifo[wp] <= mem_rd_data;
    end
endmodule

// File: tb/tb_tlp_cpl_tx.sv
// Bench for tlp_cpl_tx: requests go into a scoreboard built from the header/data rules,
// a negedge monitor checks every consumed word, stall holding and throughput.
module tb_tlp_cpl_tx;
    localparam logic [7:0] BUS  = 8'h12;
    localparam logic [4:0] DEV  = 5'd1;
    localparam logic [2:0] FUNC = 3'd1;

    logic        clk_125 = 1'b0;
    logic        sys_rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_id = '0;
    logic [7:0]  req_tag = '0;
    logic [2:0]  req_tc = '0;
    logic [1:0]  req_attr = '0;
    logic [9:0]  req_len = '0;
    logic [12:0] req_addr = '0;
    logic        mem_rd_en;
    logic [11:0] mem_addr;
    logic [15:0] mem_rd_data = '0;
    logic        tx_req, tx_rdy, tx_st, tx_end;
    logic [15:0] tx_data;

    logic [15:0] mem [4096];
    logic [17:0] exp_q [$];
    int checks = 0, errors = 0;
    int cyc = 0, acc_cyc = 0, last_cons = 0, cons_cnt = 0, done_cnt = 0, rd_cnt = 0;
    int rdy_mode = 0, low_cnt = 0;
    bit in_tlp = 0, prev_stall = 0;
    logic [17:0] prev_word, cur, e;

    tlp_cpl_tx dut (
        .clk_125(clk_125), .sys_rst(sys_rst),
        .bus_num(BUS), .dev_num(DEV), .func_num(FUNC),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .req_tag(req_tag), .req_tc(req_tc), .req_attr(req_attr),
        .req_len(req_len), .req_addr(req_addr),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .tx_req(tx_req), .tx_rdy(tx_rdy), .tx_st(tx_st), .tx_end(tx_end), .tx_data(tx_data)
    );

    always #4 clk_125 = ~clk_125;
    always @(posedge clk_125) cyc <= cyc + 1;
    always @(posedge clk_125) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // tx_rdy patterns: 0 always ready, 1 toggling, 2 random, 3 low while low_cnt>0
    initial begin
        tx_rdy = 1'b0;
        forever begin
            @(posedge clk_125); #1;
            case (rdy_mode)
                0: tx_rdy = 1'b1;
                1: tx_rdy = !tx_rdy;
                2: tx_rdy = 1'($urandom_range(0, 1));
                default: begin
                    if (low_cnt > 0) begin tx_rdy = 1'b0; low_cnt--; end
                    else tx_rdy = 1'b1;
                end
            endcase
        end
    end

    always @(negedge clk_125) begin
        if (sys_rst) begin
            in_tlp = 0; prev_stall = 0; exp_q.delete();
        end else begin
            if (mem_rd_en) rd_cnt++;
            if (in_tlp || tx_st) begin
                cur = {tx_st, tx_end, tx_data};
                if (!in_tlp && rdy_mode == 0) chk("st_lat", cyc, acc_cyc + 1);
                in_tlp = 1;
                if (prev_stall) chk("hold", cur, prev_word);
                prev_stall = !tx_rdy;
                prev_word = cur;
                if (tx_rdy) begin
                    if (exp_q.size() == 0) chk("extra", 32'(cur), 32'hFFFF_FFFF);
                    else begin e = exp_q.pop_front(); chk("word", cur, e); end
                    if (rdy_mode == 0 && !tx_st) chk("gap", cyc, last_cons + 1);
                    last_cons = cyc;
                    cons_cnt++;
                    if (tx_end) begin in_tlp = 0; done_cnt++; end
                end
            end else prev_stall = 0;
        end
    end

    task automatic model(input logic [15:0] id, input logic [7:0] tag, input logic [2:0] tc,
                         input logic [1:0] attr, input logic [9:0] len, input logic [12:0] addr);
        bit ur;
        int nd, base;
        int w [6];
        ur = (len == 0) || (len > 32);
        nd = ur ? 0 : 2 * len;
        base = (addr >> 1) & 'hFFE;
        w[0] = ((ur ? 0 : 2) << 13) | (10 << 8) | (tc << 4);
        w[1] = (attr << 12) | (ur ? 0 : len);
        w[2] = (BUS << 8) | (DEV << 3) | FUNC;
        w[3] = ur ? 'h2004 : (len * 4) % 4096;
        w[4] = id;
        w[5] = (tag << 8) | (((addr >> 2) & 31) << 2);
        for (int i = 0; i < 6; i++) exp_q.push_back({i == 0, ur && i == 5, 16'(w[i])});
        for (int i = 0; i < nd; i++) exp_q.push_back({1'b0, i == nd - 1, mem[(base + i) % 4096]});
    endtask

    task automatic issue(input logic [15:0] id, input logic [7:0] tag, input logic [2:0] tc,
                         input logic [1:0] attr, input logic [9:0] len, input logic [12:0] addr);
        int n = 0;
        model(id, tag, tc, attr, len, addr);
        req_id = id; req_tag = tag; req_tc = tc; req_attr = attr; req_len = len; req_addr = addr;
        req_valid = 1'b1;
        while (!req_ready && n < 2000) begin @(posedge clk_125); #1; n++; end
        if (!req_ready) chk("accept_to", 32'(req_ready), 1);
        @(posedge clk_125); #1;
        req_valid = 1'b0;
        acc_cyc = cyc;
        chk("tx_req_lat", 32'(tx_req), 1);
        chk("rdy_drop", 32'(req_ready), 0);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 3000) begin @(posedge clk_125); #1; n++; end
        chk("done", done_cnt, target);
    endtask

    task automatic set_mode(input int m);
        rdy_mode = m;
        repeat (2) begin @(posedge clk_125); #1; end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_ready"}, 32'(req_ready), 0);
        chk({pfx, "_txreq"}, 32'(tx_req), 0);
        chk({pfx, "_st"}, 32'(tx_st), 0);
        chk({pfx, "_end"}, 32'(tx_end), 0);
        chk({pfx, "_data"}, 32'(tx_data), 0);
        chk({pfx, "_rden"}, 32'(mem_rd_en), 0);
        chk({pfx, "_maddr"}, 32'(mem_addr), 0);
    endtask

    initial begin
        int d0, t, n, c0;
        logic [9:0] len;
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);

        repeat (3) @(posedge clk_125); #1;
        chk_zero("rst");
        sys_rst = 1'b0;
        @(posedge clk_125); #1;
        chk("rst_rel_ready", 32'(req_ready), 1);

        // basic single-DW CplD
        mem[12'h20] = 16'hDEAD; mem[12'h21] = 16'hBEEF;
        set_mode(0);
        t = done_cnt + 1;
        issue(16'h0000, 8'h05, 3'd0, 2'd0, 10'd1, 13'h0040);
        wait_done(t);

        // max length, incrementing data
        for (int i = 0; i < 64; i++) mem[i] = 16'(i);
        t = done_cnt + 1;
        issue(16'hA5C3, 8'h11, 3'd0, 2'd0, 10'd32, 13'h0000);
        wait_done(t);

        // UR: too long and zero length
        for (int k = 0; k < 2; k++) begin
            rd_cnt = 0;
            t = done_cnt + 1;
            issue(16'h1234, 8'h07, 3'd0, 2'd0, (k == 0) ? 10'd33 : 10'd0, 13'h0000);
            wait_done(t);
            chk("ur_no_rd", rd_cnt, 0);
        end

        // toggling ready
        set_mode(1);
        t = done_cnt + 1;
        issue(16'h0102, 8'h33, 3'd5, 2'd2, 10'd4, 13'h0124);
        wait_done(t);

        // long ARB stall, second request queued behind the first
        rdy_mode = 3; low_cnt = 100000;
        repeat (2) begin @(posedge clk_125); #1; end
        d0 = done_cnt;
        issue(16'h0BAD, 8'h21, 3'd1, 2'd1, 10'd2, 13'h0808);
        for (int i = 0; i < 10; i++) begin
            chk("arb_req", 32'(tx_req), 1);
            chk("arb_busy", 32'(req_ready), 0);
            @(posedge clk_125); #1;
        end
        low_cnt = 0;
        issue(16'h0C0D, 8'h22, 3'd2, 2'd3, 10'd3, 13'h0A10);
        chk("b_after_end", done_cnt, d0 + 1);
        wait_done(d0 + 2);

        // address wrap at the top of the window
        set_mode(2);
        t = done_cnt + 1;
        issue(16'h7777, 8'h44, 3'd7, 2'd0, 10'd4, 13'h1FFC);
        wait_done(t);

        // randomized requests
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 9))
                0: len = 10'd0;
                1: len = 10'($urandom_range(33, 1023));
                default: len = 10'($urandom_range(1, 32));
            endcase
            set_mode(int'($urandom_range(0, 2)));
            rd_cnt = 0;
            t = done_cnt + 1;
            issue(16'($urandom), 8'($urandom), 3'($urandom), 2'($urandom), len, 13'($urandom));
            wait_done(t);
            if (len == 0 || len > 32) chk("ur_no_rd", rd_cnt, 0);
        end

        // reset in the middle of DATA, then recover
        set_mode(0);
        c0 = cons_cnt;
        issue(16'h4242, 8'h55, 3'd0, 2'd0, 10'd8, 13'h0300);
        n = 0;
        while (cons_cnt < c0 + 10 && n < 200) begin @(posedge clk_125); #1; n++; end
        chk("mid_data", 32'(cons_cnt >= c0 + 10), 1);
        sys_rst = 1'b1;
        @(posedge clk_125); #1;
        chk_zero("abort");
        sys_rst = 1'b0;
        @(posedge clk_125); #1;
        chk("abort_ready", 32'(req_ready), 1);
        t = done_cnt + 1;
        issue(16'h0001, 8'h66, 3'd0, 2'd0, 10'd1, 13'h0050);
        wait_done(t);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tlp_cpl_tx.md
Name: tlp_cpl_tx

Overview:
- Completion transmitter on the PCIe transaction-layer transmit side of the ethpipe mid-layer. It is the responder to incoming memory-read TLPs.
- The TLP receive decoder hands it one decoded read request at a time. The block fetches the data from a 16-bit BAR-side memory and emits a 3DW CplD, or a Cpl with UR status, onto the core's 16-bit tx_req/tx_rdy/tx_st/tx_end/tx_data interface.

Parameters:
- ADDR_W, 13, byte-address width of the BAR memory window (req_addr width)
- MAX_LEN_DW, 32, largest read length in DW served in one completion; longer or zero-length requests get UR

Ports:
- clk_125  in  1  system clock, 125 MHz
- sys_rst  in  1  synchronous reset, active-high
- bus_num  in  8  completer bus number
- dev_num  in  5  completer device number
- func_num  in  3  completer function number
- req_valid  in  1  decoded read request present
- req_ready  out  1  request accepted when req_valid&req_ready
- req_id  in  16  requester ID
- req_tag  in  8  request tag
- req_tc  in  3  traffic class
- req_attr  in  2  attributes
- req_len  in  10  length in DW (0 encodes 1024)
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W-1  16-bit word address
- mem_rd_data  in  16  read data, valid exactly 1 cycle after mem_rd_en
- tx_req  out  1  request to transmit a TLP
- tx_rdy  in  1  core ready; a word is consumed on every cycle tx_rdy=1 while streaming
- tx_st  out  1  first word of TLP
- tx_end  out  1  last word of TLP
- tx_data  out  16  TLP word, big-endian DW order, high half first

Behaviour:
- Reset values: req_ready=0, tx_req=0, tx_st=0, tx_end=0, tx_data=0, mem_rd_en=0, mem_addr=0. Reset mid-TLP aborts immediately; the state machine returns to IDLE on the next cycle.
- States and transitions:
  - IDLE: req_ready=1. On req_valid, capture all req_* fields and go to ARB next cycle. req_ready drops in the same cycle the request is captured, so exactly one request is outstanding at a time.
  - ARB: tx_req=1 until tx_rdy=1 is seen, then tx_req=0 and go to HDR.
  - HDR: 6 words, first word with tx_st=1.
  - DATA: 2*len words; the last word has tx_end=1.
  - Back to IDLE.
- If the request is UR, there is no DATA state and the 6th header word carries tx_end.
- UR condition: req_len==0 or req_len>MAX_LEN_DW.
- Flow control: while tx_rdy=0 during HDR/DATA, tx_data/tx_st/tx_end hold their values and no word advances. Memory prefetch must absorb the 1-cycle read latency, so with tx_rdy held at 1 the output runs one word per cycle with no bubbles.
- Header words (CplD / UR Cpl):
  - w0 = {1'b0, fmt, 5'b01010, 1'b0, tc, 4'b0}, with fmt=2'b10 for CplD and 2'b00 for UR.
  - w1 = {2'b00, attr, 2'b00, length}; length=req_len for CplD, 0 for UR.
  - w2 = {bus_num, dev_num, func_num}.
  - w3 = {status, 1'b0, byte_count[11:0]}; status=000 for SC, 001 for UR; byte_count=req_len*4 (mod 4096) for CplD, 4 for UR.
  - w4 = req_id.
  - w5 = {req_tag, 1'b0, req_addr[6:2], 2'b00}.
- Data: the word address starts at req_addr[ADDR_W-1:1] with bit 0 forced to 0 and increments by 1 per word. It wraps modulo 2^(ADDR_W-1) at the end of the window.
- Latency: a request accepted in cycle N produces tx_req=1 in cycle N+1. tx_st is asserted in the cycle after tx_rdy is first sampled high.
- The block never reads memory for UR completions.

Test Plan:
- bus=0x12, dev=1, func=1; request id=0x0000, tag=0x05, tc=0, attr=0, len=1, addr=0x40; mem[0x20]=0xDEAD, mem[0x21]=0xBEEF; tx_rdy=1 -> expected stream: 0x4A00(st), 0x0001, 0x1209, 0x0004, 0x0000, 0x0540, 0xDEAD, 0xBEEF(end); 8 consecutive cycles.
- len=32, addr=0x0, mem[i]=i -> 6 header words with w1=0x0020 and w3=0x0080, then 64 data words 0x0000..0x003F, no gaps, tx_end on 0x003F.
- len=33 (and, separately, len=0), tag=0x07 -> UR Cpl: 0x0A00, 0x0000, 0x1209, 0x2004, req_id, 0x0700(end); mem_rd_en never asserted.
- tx_rdy toggles 1/0 every cycle during a len=4 CplD -> identical word sequence to the tx_rdy=1 case, each word held across its stall cycles, tx_st/tx_end each seen on exactly one consuming cycle.
- tx_rdy held low for 10 cycles after request -> tx_req stays 1 for 10 cycles and req_ready stays 0; a second req_valid is not accepted until tx_end has been consumed.
- sys_rst asserted in the middle of DATA -> all outputs are 0 in the next cycle and req_ready=1 in the cycle after reset is released; a new len=1 request then completes correctly.
